// File: rtl/snoopy_pkg.sv
// Shared types for the snoop controller: MSI line states, bus snoop
// commands and the controller FSM encoding.
package snoopy_pkg;

   typedef enum logic [1:0] {
      INVALID  = 2'd0,
      SHARED   = 2'd1,
      MODIFIED = 2'd2
   } msi_state_t;

   typedef enum logic [1:0] {
      BUS_READ           = 2'd0,
      BUS_READ_EXCLUSIVE = 2'd1,
      BUS_INVALIDATE     = 2'd2,
      BUS_RESERVED       = 2'd3
   } bus_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_UPDATE = 3'd3,
      ST_DONE   = 3'd4
   } fsm_state_t;

endpackage

// File: rtl/snoopy_controller.sv
// Bus snoop controller: looks up a snooped block in the cache, streams a
// MODIFIED block out word by word, then downgrades/invalidates the line.
module snoopy_controller
   import snoopy_pkg::*;
#(
   parameter int TAG_WIDTH    = 6,
   parameter int INDEX_WIDTH  = 6,
   parameter int OFFSET_WIDTH = 4,
   parameter int DATA_WIDTH   = 16
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        snoopValid,
   output logic                                        snoopReady,
   input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] snoopAddress,
   input  logic [1:0]                                  snoopCommand,
   output logic                                        flushValid,
   input  logic                                        flushReady,
   output logic [DATA_WIDTH-1:0]                       flushData,
   output logic [OFFSET_WIDTH-1:0]                     flushOffset,
   output logic                                        snoopDone,
   output logic                                        snoopFlushed,
   output logic [INDEX_WIDTH-1:0]                      snoopyIndex,
   output logic [TAG_WIDTH-1:0]                        snoopyTagIn,
   output logic [OFFSET_WIDTH-1:0]                     snoopyOffset,
   output logic [1:0]                                  snoopyStateIn,
   output logic                                        snoopyWriteState,
   input  logic                                        snoopyHit,
   input  logic [1:0]                                  snoopyStateOut,
   input  logic [DATA_WIDTH-1:0]                       snoopyDataOut
);

   localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

   fsm_state_t              r_state;
   bus_cmd_t                r_cmd;
   logic [TAG_WIDTH-1:0]    r_tag;
   logic [INDEX_WIDTH-1:0]  r_index;
   logic [OFFSET_WIDTH-1:0] r_count;
   logic                    r_flushed;

   // The snooped word offset is irrelevant: a hit always supplies the whole block.
   logic w_unused_offset;
   assign w_unused_offset = ^snoopAddress[OFFSET_WIDTH-1:0];

   logic w_last_word;
   assign w_last_word = (r_count == {OFFSET_WIDTH{1'b1}});

   // Snoop FSM: accept, look up, optionally flush, update line state, complete.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cmd     <= BUS_READ;
         r_tag     <= '0;
         r_index   <= '0;
         r_count   <= '0;
         r_flushed <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (snoopValid) begin
                  r_tag     <= snoopAddress[ADDR_WIDTH-1 -: TAG_WIDTH];
                  r_index   <= snoopAddress[OFFSET_WIDTH +: INDEX_WIDTH];
                  r_cmd     <= bus_cmd_t'(snoopCommand);
                  r_flushed <= 1'b0;
                  r_state   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!snoopyHit || r_cmd == BUS_RESERVED) begin
                  r_state <= ST_DONE;
               end else if (snoopyStateOut == MODIFIED) begin
                  r_count   <= '0;
                  r_flushed <= 1'b1;
                  r_state   <= ST_FLUSH;
               end else if (snoopyStateOut == SHARED) begin
                  // A read leaves a SHARED line untouched; anything else must invalidate it.
                  r_state <= (r_cmd == BUS_READ) ? ST_DONE : ST_UPDATE;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            ST_FLUSH: begin
               if (flushReady) begin
                  r_count <= r_count + 1'b1;
                  if (w_last_word) begin
                     r_state <= ST_UPDATE;
                  end
               end
            end
            ST_UPDATE: r_state <= ST_DONE;
            ST_DONE:   r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode directly from the registered state so they follow the FSM without glitching on inputs.
   always_comb begin
      snoopReady       = (r_state == ST_IDLE);
      flushValid       = (r_state == ST_FLUSH);
      flushData        = (r_state == ST_FLUSH) ? snoopyDataOut : '0;
      flushOffset      = r_count;
      snoopDone        = (r_state == ST_DONE);
      snoopFlushed     = (r_state == ST_DONE) && r_flushed;
      snoopyIndex      = r_index;
      snoopyTagIn      = r_tag;
      snoopyOffset     = r_count;
      snoopyWriteState = (r_state == ST_UPDATE);
      snoopyStateIn    = ((r_state == ST_UPDATE) && (r_cmd == BUS_READ)) ? SHARED : INVALID;
   end

endmodule

// File: tb/tb_snoopy_controller.sv
// Randomized directed bench for snoopy_controller with a cache-side model.
`define CHK(TAG, OBS, EXP) \
   begin \
      total++; \
      assert ((OBS) === (EXP)) else begin \
         bad++; \
         $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
      end \
   end

module tb_snoopy_controller;
   localparam int TW = 6, IW = 6, OW = 4, DW = 16, AW = TW + IW + OW, NW = 1 << OW;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          snoopValid = 1'b0;
   logic          snoopReady;
   logic [AW-1:0] snoopAddress = '0;
   logic [1:0]    snoopCommand = 2'd0;
   logic          flushValid;
   logic          flushReady = 1'b1;
   logic [DW-1:0] flushData;
   logic [OW-1:0] flushOffset;
   logic          snoopDone;
   logic          snoopFlushed;
   logic [IW-1:0] snoopyIndex;
   logic [TW-1:0] snoopyTagIn;
   logic [OW-1:0] snoopyOffset;
   logic [1:0]    snoopyStateIn;
   logic          snoopyWriteState;
   logic          snoopyHit = 1'b0;
   logic [1:0]    snoopyStateOut = 2'd0;
   logic [DW-1:0] snoopyDataOut;

   logic [DW-1:0] mem [NW];
   int total = 0;
   int bad = 0;

   assign snoopyDataOut = mem[snoopyOffset];

   always #5 clock = ~clock;

   snoopy_controller #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset),
      .snoopValid(snoopValid), .snoopReady(snoopReady),
      .snoopAddress(snoopAddress), .snoopCommand(snoopCommand),
      .flushValid(flushValid), .flushReady(flushReady),
      .flushData(flushData), .flushOffset(flushOffset),
      .snoopDone(snoopDone), .snoopFlushed(snoopFlushed),
      .snoopyIndex(snoopyIndex), .snoopyTagIn(snoopyTagIn), .snoopyOffset(snoopyOffset),
      .snoopyStateIn(snoopyStateIn), .snoopyWriteState(snoopyWriteState),
      .snoopyHit(snoopyHit), .snoopyStateOut(snoopyStateOut), .snoopyDataOut(snoopyDataOut)
   );

   // mode: 0 = flushReady high, 1 = toggling, 2 = random. hold keeps a second request pending.
   task automatic snoop(input logic [1:0] cmd, input logic hit, input logic [1:0] st,
                        input int mode, input bit hold);
      logic [AW-1:0] addr;
      logic [AW-1:0] addr2;
      int   n, idx_err, data_err, ord_err, writes, dones;
      int   words[$];
      logic [1:0] wval;
      logic fl;
      bit   exp_flush, exp_upd;
      int   exp_lat;
      addr = AW'($urandom);
      addr2 = AW'($urandom);
      idx_err = 0; data_err = 0; ord_err = 0; writes = 0; dones = 0;
      wval = 2'd0; fl = 1'b0;
      for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
      // Reference: what the snoop rules say must happen for this request.
      exp_flush = hit && (st == 2'd2) && (cmd != 2'd3);
      exp_upd   = exp_flush || (hit && (st == 2'd1) && (cmd != 2'd3) && (cmd != 2'd0));
      exp_lat   = !exp_upd ? 3 : (exp_flush ? NW + 4 : 4);

      @(negedge clock);
      `CHK("ready_before_req", snoopReady, 1'b1)
      snoopValid = 1'b1; snoopAddress = addr; snoopCommand = cmd;
      snoopyHit = hit; snoopyStateOut = st;
      @(negedge clock);
      if (hold) begin
         snoopAddress = addr2; snoopCommand = 2'd0;
      end else begin
         snoopValid = 1'b0; snoopAddress = AW'($urandom); snoopCommand = 2'($urandom);
      end
      n = 1;
      while (!snoopReady && n < 200) begin
         flushReady = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(n % 2) : 1'($urandom % 2);
         if (snoopyIndex !== addr[OW +: IW] || snoopyTagIn !== addr[AW-1 -: TW]) idx_err++;
         if (flushValid) begin
            if (flushData !== mem[flushOffset]) data_err++;
            if (flushReady) words.push_back(int'(flushOffset));
         end
         if (snoopyWriteState) begin writes++; wval = snoopyStateIn; end
         if (snoopDone) begin dones++; fl = snoopFlushed; end
         @(negedge clock);
         n++;
      end
      flushReady = 1'b1;
      `CHK("no_timeout", (n < 200), 1'b1)
      `CHK("lookup_addr_held", idx_err, 0)
      `CHK("flush_data", data_err, 0)
      `CHK("flush_word_count", words.size(), exp_flush ? NW : 0)
      foreach (words[i]) if (words[i] != i) ord_err++;
      `CHK("flush_order", ord_err, 0)
      `CHK("state_writes", writes, exp_upd ? 1 : 0)
      if (exp_upd) `CHK("state_written", wval, (cmd == 2'd0) ? 2'd1 : 2'd0)
      `CHK("done_pulses", dones, 1)
      `CHK("flushed_flag", fl, 1'(exp_flush))
      if (mode == 0) `CHK("latency", n, exp_lat)
      if (hold) begin
         @(negedge clock);
         `CHK("held_req_accepted", snoopReady, 1'b0)
         `CHK("held_req_index", snoopyIndex, addr2[OW +: IW])
         snoopValid = 1'b0; snoopyHit = 1'b0;
         @(negedge clock);
         @(negedge clock);
         `CHK("held_req_finished", snoopReady, 1'b1)
      end
   endtask

   initial begin
      int guard;
      logic [1:0] rc, rs;
      for (int i = 0; i < NW; i++) mem[i] = '0;
      #12;
      `CHK("rst_ready", snoopReady, 1'b1)
      `CHK("rst_flushValid", flushValid, 1'b0)
      `CHK("rst_flushData", flushData, 16'h0)
      `CHK("rst_flushOffset", flushOffset, 4'h0)
      `CHK("rst_done", snoopDone, 1'b0)
      `CHK("rst_flushed", snoopFlushed, 1'b0)
      `CHK("rst_write", snoopyWriteState, 1'b0)
      `CHK("rst_stateIn", snoopyStateIn, 2'd0)
      `CHK("rst_index", snoopyIndex, 6'h0)
      `CHK("rst_tag", snoopyTagIn, 6'h0)
      @(negedge clock);
      reset = 1'b1;

      snoop(2'd0, 1'b0, 2'd2, 0, 1'b0);   // miss
      snoop(2'd2, 1'b1, 2'd1, 0, 1'b0);   // SHARED invalidate
      snoop(2'd0, 1'b1, 2'd1, 0, 1'b0);   // SHARED read, no change
      snoop(2'd0, 1'b1, 2'd2, 0, 1'b0);   // MODIFIED read flush
      snoop(2'd1, 1'b1, 2'd2, 1, 1'b0);   // MODIFIED read-exclusive, toggling ready
      snoop(2'd1, 1'b1, 2'd0, 0, 1'b0);   // hit on INVALID line
      snoop(2'd3, 1'b1, 2'd2, 0, 1'b0);   // reserved command
      snoop(2'd2, 1'b1, 2'd2, 2, 1'b1);   // flush with a second request held pending

      // Reset in the middle of a flush.
      @(negedge clock);
      snoopValid = 1'b1; snoopAddress = AW'($urandom); snoopCommand = 2'd0;
      snoopyHit = 1'b1; snoopyStateOut = 2'd2; flushReady = 1'b1;
      @(negedge clock);
      snoopValid = 1'b0;
      guard = 0;
      while (!(flushValid && flushOffset == 4'd7) && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      `CHK("reached_offset7", guard < 50, 1'b1)
      #1 reset = 1'b0;
      #1;
      `CHK("abort_ready", snoopReady, 1'b1)
      `CHK("abort_flushValid", flushValid, 1'b0)
      `CHK("abort_offset", flushOffset, 4'h0)
      `CHK("abort_stateIn", snoopyStateIn, 2'd0)
      repeat (2) begin
         @(negedge clock);
         `CHK("abort_no_write", snoopyWriteState, 1'b0)
         `CHK("abort_no_done", snoopDone, 1'b0)
      end
      reset = 1'b1;
      snoop(2'd0, 1'b1, 2'd2, 0, 1'b0);   // normal after abort

      for (int k = 0; k < 20; k++) begin
         rc = 2'($urandom);
         rs = 2'($urandom);
         snoop(rc, 1'($urandom % 2), rs, int'($urandom % 3), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
